// File: rtl/types_pkg.sv
// Shared types for the cipher output path: holder state enum and default holder depth.
package types_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        READY,
        WAIT_RELEASE
    } output_holder_state_t;

    localparam int unsigned OUTPUT_HOLDER_DEPTH = 4;

endpackage

// File: rtl/ack_sync.sv
// Two-flop synchronizer for a raw chip-pin input; resets to 0.
module ack_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/output_holder.sv
// Byte FIFO between the keystream XOR stage and output_mux, popped once per ack pin high phase.
// Define OUTPUT_HOLDER_OVERFLOW_EN to add the sticky overflow flag.
module output_holder
    import types_pkg::*;
#(
    parameter int unsigned DEPTH = OUTPUT_HOLDER_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   byte_in,
    input  logic                         byte_valid,
    output logic                         holder_full,
    input  logic                         output_acknowledge,
`ifdef OUTPUT_HOLDER_OVERFLOW_EN
    output logic                         overflow,
`endif
    output logic [7:0]                   data_out,
    output output_holder_state_t         output_holder_state,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic                 ack_s;
    logic [7:0]           mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count_next;
    logic                 push;
    logic                 pop;
    output_holder_state_t state;
    output_holder_state_t state_next;

    ack_sync u_ack_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (output_acknowledge),
        .sync_out (ack_s)
    );

    always_comb begin
        pop  = (state == READY) && ack_s;
        // A full holder still accepts a byte when the head leaves on the same edge.
        push = byte_valid && ((count < DEPTH_C) || pop);

        unique case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase

        state_next = state;
        unique case (state)
            EMPTY: begin
                if ((count_next != '0) && !ack_s) state_next = READY;
            end
            READY: begin
                if (ack_s) state_next = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (!ack_s) state_next = (count_next != '0) ? READY : EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            holder_full <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            holder_full <= (count_next == DEPTH_C);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset: data_out is gated while EMPTY and pointers restart at 0.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= byte_in;
    end

`ifdef OUTPUT_HOLDER_OVERFLOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (byte_valid && !push) begin
            overflow <= 1'b1;
        end
    end
`endif

    assign output_holder_state = state;
    assign data_out            = (state == EMPTY) ? 8'h00 : mem[rd_ptr];

endmodule

// File: doc/output_holder.md
# output_holder

Byte buffer between the keystream XOR stage and `output_mux`. It captures cipher output bytes into a small FIFO and presents the head byte with a state enum to `output_mux`. It pops one byte per completed level handshake on the external `output_acknowledge` pin, and back-pressures the upstream stage when full.

## Interface

**Parameters**
- `DEPTH`, default 4: FIFO entries. Must be a power of two and ≥ 2.

**Ports** (name, direction, width, meaning)
- `clk` input, 1: single clock domain.
- `rst_n` input, 1: reset, asynchronous, active-low.
- `byte_in` input, 8: cipher output byte from the XOR stage.
- `byte_valid` input, 1: `byte_in` is valid this cycle.
- `holder_full` output, 1: registered; high when count == DEPTH. Upstream must not assert `byte_valid` while high.
- `output_acknowledge` input, 1: raw chip pin, asynchronous to `clk`.
- `data_out` output, 8: head byte, drives `output_mux` `data_in`.
- `output_holder_state` output, `output_holder_state_t`: drives `output_mux`.
- `count` output, $clog2(DEPTH+1): bytes currently held.
- `overflow` output, 1: present only with the macro (see Configuration).

## Operation

**Acknowledge synchronizer**
- `output_acknowledge` passes through a 2-flop synchronizer; the second-flop output is `ack_s`.
- Only `ack_s` is used internally.

**Push**
- Accepted at a clock edge when `byte_valid` && (count < DEPTH || pop on the same edge).
- Otherwise the byte is dropped.
- Write to `mem[wr_ptr]`, then `wr_ptr` += 1 (wraps modulo DEPTH).

**Pop**
- Occurs only on the READY→WAIT_RELEASE transition.
- `rd_ptr` += 1 (wraps modulo DEPTH).

**count**
- count_next = count + push − pop.
- Simultaneous push and pop leaves count unchanged.

**State machine** (`output_holder_state_t`: EMPTY, READY, WAIT_RELEASE)
- EMPTY → READY when count_next > 0 && !`ack_s`. Otherwise stay in EMPTY, including while `ack_s` is held high.
- READY → WAIT_RELEASE when `ack_s` is high; pop on this edge.
- WAIT_RELEASE → READY when !`ack_s` && count_next > 0.
- WAIT_RELEASE → EMPTY when !`ack_s` && count_next == 0.
- WAIT_RELEASE otherwise holds. Exactly one byte is popped per high phase of the pin.

**data_out**
- READY or WAIT_RELEASE: `mem[rd_ptr]`.
- EMPTY: 8'h00.

## Timing

**Reset values** (any time `rst_n` is low, including mid-operation)
- state = EMPTY, count = 0, pointers = 0, `holder_full` = 0, `data_out` = 8'h00, sync flops = 0, `overflow` = 0.
- Buffered bytes are discarded.

**Push latency**
- `byte_valid` sampled at edge k → after edge k: count = 1, state = READY, `data_out` = byte. This assumes the holder was EMPTY and `ack_s` is low.

**Ack latency**
- Pin rises before edge j → `ack_s` high after edge j+1 → pop and WAIT_RELEASE after edge j+2.
- Release is symmetric: pin low → READY/EMPTY three edges later.

**Boundary cases**
- `holder_full` is registered, so it reflects count after each edge.
- Push while full with no same-edge pop: byte lost, count stays DEPTH.
- Push while full with a same-edge pop: accepted.
- Pointer wrap from DEPTH−1 to 0 is seamless.
- Push on the same edge as the READY→WAIT_RELEASE pop: both take effect; head advances to the next-oldest byte.

## Configuration

- `OUTPUT_HOLDER_OVERFLOW_EN` defined:
  - The `overflow` port exists.
  - It is a sticky flag set on any dropped push.
  - It is cleared only by reset.
- Macro undefined:
  - The port and its logic are absent.
  - Dropped pushes are silent; all other behaviour is identical.

## Structure

- `output_holder_state_t` (EMPTY, READY, WAIT_RELEASE) lives in `types_pkg`. `output_mux` keys on READY only.
- The default-depth constant `OUTPUT_HOLDER_DEPTH` = 4 also lives in `types_pkg`.
- Sub-module `ack_sync`: 2-flop synchronizer with asynchronous active-low reset to 0, reusable for other chip-pin inputs.

## Test plan

1. **Reset mid-operation.** Push 8'hA5, assert `rst_n` low asynchronously. → Immediately: state EMPTY, count 0, `data_out` 8'h00.
2. **Single byte handshake.** Push 8'h3C, then pulse the pin high for 5 cycles, then low. → READY with 8'h3C one edge after the push; WAIT_RELEASE 3 edges after the pin rises; EMPTY 3 edges after the pin falls.
3. **Fill and overflow.** DEPTH = 4: push 8'h01–8'h05 on consecutive edges with no ack. → `holder_full` high after the 4th push; 8'h05 dropped; `overflow` = 1 with the macro. Four handshakes then yield 01, 02, 03, 04.
4. **Simultaneous push/pop while full.** Push on the same edge as the pop. → count stays 4; new byte becomes the last entry; no overflow.
5. **Ack held high while EMPTY.** Hold the pin high, then push 8'h77. → State stays EMPTY until the pin goes low, then READY with 8'h77; no byte popped.
6. **Pointer wrap.** Ten push/ack cycles with bytes 8'h10–8'h19 at DEPTH = 4. → All ten appear in order; count ends at 0.
